// File: rtl/ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control path: encodings, control bundles
// and the forwarding-select helper used by the hazard unit.
`timescale 1ns/1ps
package ctrl_pkg;

    localparam int CP_REG_AW  = 5;
    localparam int CP_ALUOP_W = 2;

    localparam logic [CP_ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
    localparam logic [CP_ALUOP_W-1:0] ALUOP_BR    = 2'b01;
    localparam logic [CP_ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [CP_ALUOP_W-1:0] ALUOP_JMP   = 2'b11;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Full decoder bundle for the instruction sitting in ID.
    typedef struct packed {
        logic                  alusrc;
        logic                  regdst;
        logic                  memwrite;
        logic                  memread;
        logic                  beq;
        logic                  bne;
        logic                  jump;
        logic                  memtoreg;
        logic                  regwrite;
        logic [CP_ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam int CTRL_W = 9 + CP_ALUOP_W;

    // Jump has already acted in ID, so the ID/EX register does not carry it.
    typedef struct packed {
        logic                  alusrc;
        logic                  regdst;
        logic                  memwrite;
        logic                  memread;
        logic                  beq;
        logic                  bne;
        logic                  memtoreg;
        logic                  regwrite;
        logic [CP_ALUOP_W-1:0] aluop;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = 8 + CP_ALUOP_W;
    localparam ex_ctrl_t EX_BUBBLE = ex_ctrl_t'({EX_CTRL_W{1'b0}});

    function automatic ex_ctrl_t to_ex_ctrl(input ctrl_t c);
        ex_ctrl_t e;
        e.alusrc   = c.alusrc;
        e.regdst   = c.regdst;
        e.memwrite = c.memwrite;
        e.memread  = c.memread;
        e.beq      = c.beq;
        e.bne      = c.bne;
        e.memtoreg = c.memtoreg;
        e.regwrite = c.regwrite;
        e.aluop    = c.aluop;
        return e;
    endfunction

    // EX/MEM match beats MEM/WB; $0 is never a forwarding source.
    function automatic logic [1:0] fwd_select(
        input logic                 mem_rw,
        input logic [CP_REG_AW-1:0] mem_dst,
        input logic                 wb_rw,
        input logic [CP_REG_AW-1:0] wb_dst,
        input logic [CP_REG_AW-1:0] src
    );
        logic [1:0] sel;
        if (mem_rw && (mem_dst != {CP_REG_AW{1'b0}}) && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_rw && (wb_dst != {CP_REG_AW{1'b0}}) && (wb_dst == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Combinational hazard/forwarding unit: branch redirect and flush, load-use stall,
// jump redirect, and EX operand forwarding selects.
`timescale 1ns/1ps
module hazard_fwd_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = CP_REG_AW
)(
    input  logic              i_ex_beq,
    input  logic              i_ex_bne,
    input  logic              i_ex_zero,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_dec_jump,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_wb_regwrite,
    input  logic [REG_AW-1:0] i_wb_dst,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_ifid_flush,
    output logic [1:0]        o_pc_sel,
    output logic              o_idex_bubble,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    logic w_taken;
    logic w_load_use;

    assign w_taken = (i_ex_beq & i_ex_zero) | (i_ex_bne & ~i_ex_zero);

    // A jump only reads rs, so its rt field cannot create a load-use hazard.
    assign w_load_use = i_ex_memread
                      & (i_ex_rt != {REG_AW{1'b0}})
                      & ((i_ex_rt == i_id_rs) | ((i_ex_rt == i_id_rt) & ~i_dec_jump));

    // Redirect/stall resolution: taken branch, then load-use, then jump.
    always_comb begin
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_pc_sel      = PC_SEL_SEQ;
        o_idex_bubble = 1'b0;
        if (w_taken) begin
            o_pc_sel      = PC_SEL_BR;
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (w_load_use) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
        end else if (i_dec_jump) begin
            o_pc_sel      = PC_SEL_JMP;
            o_ifid_flush  = 1'b1;
        end else begin
            o_pc_sel      = PC_SEL_SEQ;
        end
    end

    // Operand forwarding selects from the EX/MEM and MEM/WB destinations.
    always_comb begin
        o_fwd_a = fwd_select(i_mem_regwrite, i_mem_dst, i_wb_regwrite, i_wb_dst, i_ex_rs);
        o_fwd_b = fwd_select(i_mem_regwrite, i_mem_dst, i_wb_regwrite, i_wb_dst, i_ex_rt);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-path stage registers (ID/EX, EX/MEM, MEM/WB) of the 5-stage MIPS pipeline;
// hazard and forwarding decisions come from hazard_fwd_unit.
`timescale 1ns/1ps
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = CP_REG_AW,
    parameter int ALUOP_W = CP_ALUOP_W
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               dec_alusrc,
    input  logic               dec_regdst,
    input  logic               dec_memwrite,
    input  logic               dec_memread,
    input  logic               dec_beq,
    input  logic               dec_bne,
    input  logic               dec_jump,
    input  logic               dec_memtoreg,
    input  logic               dec_regwrite,
    input  logic [ALUOP_W-1:0] dec_aluop,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_zero,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_memtoreg,
    output logic               wb_regwrite,
    output logic [REG_AW-1:0]  wb_dst,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic [1:0]         pc_sel,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    ctrl_t             w_dec_ctrl;
    ex_ctrl_t          r_idex_ctrl;
    logic [REG_AW-1:0] r_idex_rs;
    logic [REG_AW-1:0] r_idex_rt;
    logic [REG_AW-1:0] r_idex_rd;
    logic [REG_AW-1:0] w_ex_dst;
    logic              w_idex_bubble;

    logic              r_exmem_memread;
    logic              r_exmem_memwrite;
    logic              r_exmem_memtoreg;
    logic              r_exmem_regwrite;
    logic [REG_AW-1:0] r_exmem_dst;

    logic              r_memwb_memtoreg;
    logic              r_memwb_regwrite;
    logic [REG_AW-1:0] r_memwb_dst;

    assign w_dec_ctrl = '{
        alusrc:   dec_alusrc,
        regdst:   dec_regdst,
        memwrite: dec_memwrite,
        memread:  dec_memread,
        beq:      dec_beq,
        bne:      dec_bne,
        jump:     dec_jump,
        memtoreg: dec_memtoreg,
        regwrite: dec_regwrite,
        aluop:    dec_aluop
    };

    assign w_ex_dst = r_idex_ctrl.regdst ? r_idex_rd : r_idex_rt;

    hazard_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_hazard_fwd (
        .i_ex_beq       (r_idex_ctrl.beq),
        .i_ex_bne       (r_idex_ctrl.bne),
        .i_ex_zero      (ex_zero),
        .i_ex_memread   (r_idex_ctrl.memread),
        .i_ex_rs        (r_idex_rs),
        .i_ex_rt        (r_idex_rt),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_dec_jump     (w_dec_ctrl.jump),
        .i_mem_regwrite (r_exmem_regwrite),
        .i_mem_dst      (r_exmem_dst),
        .i_wb_regwrite  (r_memwb_regwrite),
        .i_wb_dst       (r_memwb_dst),
        .o_pc_write     (pc_write),
        .o_ifid_write   (ifid_write),
        .o_ifid_flush   (ifid_flush),
        .o_pc_sel       (pc_sel),
        .o_idex_bubble  (w_idex_bubble),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
    );

    // ID/EX: a squashed or stalled slot becomes an all-zero bubble, register fields included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex_ctrl <= EX_BUBBLE;
            r_idex_rs   <= {REG_AW{1'b0}};
            r_idex_rt   <= {REG_AW{1'b0}};
            r_idex_rd   <= {REG_AW{1'b0}};
        end else if (w_idex_bubble) begin
            r_idex_ctrl <= EX_BUBBLE;
            r_idex_rs   <= {REG_AW{1'b0}};
            r_idex_rt   <= {REG_AW{1'b0}};
            r_idex_rd   <= {REG_AW{1'b0}};
        end else begin
            r_idex_ctrl <= to_ex_ctrl(w_dec_ctrl);
            r_idex_rs   <= id_rs;
            r_idex_rt   <= id_rt;
            r_idex_rd   <= id_rd;
        end
    end

    // EX/MEM advances unconditionally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exmem_memread  <= 1'b0;
            r_exmem_memwrite <= 1'b0;
            r_exmem_memtoreg <= 1'b0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_dst      <= {REG_AW{1'b0}};
        end else begin
            r_exmem_memread  <= r_idex_ctrl.memread;
            r_exmem_memwrite <= r_idex_ctrl.memwrite;
            r_exmem_memtoreg <= r_idex_ctrl.memtoreg;
            r_exmem_regwrite <= r_idex_ctrl.regwrite;
            r_exmem_dst      <= w_ex_dst;
        end
    end

    // MEM/WB advances unconditionally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memwb_memtoreg <= 1'b0;
            r_memwb_regwrite <= 1'b0;
            r_memwb_dst      <= {REG_AW{1'b0}};
        end else begin
            r_memwb_memtoreg <= r_exmem_memtoreg;
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_dst      <= r_exmem_dst;
        end
    end

    assign ex_alusrc    = r_idex_ctrl.alusrc;
    assign ex_aluop     = r_idex_ctrl.aluop;
    assign mem_memread  = r_exmem_memread;
    assign mem_memwrite = r_exmem_memwrite;
    assign wb_memtoreg  = r_memwb_memtoreg;
    assign wb_regwrite  = r_memwb_regwrite;
    assign wb_dst       = r_memwb_dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: a per-slot instruction model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_ctrl_pipe;

    typedef struct packed {
        logic       alusrc;
        logic       regdst;
        logic       memwrite;
        logic       memread;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_alusrc, dec_regdst, dec_memwrite, dec_memread, dec_beq, dec_bne;
    logic       dec_jump, dec_memtoreg, dec_regwrite;
    logic [1:0] dec_aluop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic       ex_alusrc;
    logic [1:0] ex_aluop;
    logic       mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite;
    logic [4:0] wb_dst;
    logic       pc_write, ifid_write, ifid_flush;
    logic [1:0] pc_sel, fwd_a, fwd_b;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .reset(reset),
        .dec_alusrc(dec_alusrc), .dec_regdst(dec_regdst), .dec_memwrite(dec_memwrite),
        .dec_memread(dec_memread), .dec_beq(dec_beq), .dec_bne(dec_bne), .dec_jump(dec_jump),
        .dec_memtoreg(dec_memtoreg), .dec_regwrite(dec_regwrite), .dec_aluop(dec_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .wb_dst(wb_dst), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    // Instruction occupying each later stage: [0]=EX, [1]=MEM, [2]=WB.
    instr_t      pipe [3];
    logic [20:0] sb_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        last_stall = 1'b0;
    logic        last_flush = 1'b0;
    localparam instr_t NOP = 26'd0;

    function automatic instr_t mk_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = NOP;
        x.regdst = 1'b1; x.regwrite = 1'b1; x.aluop = 2'b10;
        x.rs = rs; x.rt = rt; x.rd = rd;
        return x;
    endfunction

    function automatic instr_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
        instr_t x = NOP;
        x.alusrc = 1'b1; x.memread = 1'b1; x.memtoreg = 1'b1; x.regwrite = 1'b1;
        x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic instr_t mk_sw(input logic [4:0] rt, input logic [4:0] rs);
        instr_t x = NOP;
        x.alusrc = 1'b1; x.memwrite = 1'b1;
        x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic instr_t mk_br(input logic ne, input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = NOP;
        x.beq = ~ne; x.bne = ne; x.aluop = 2'b01;
        x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic instr_t mk_j(input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = NOP;
        x.jump = 1'b1; x.aluop = 2'b11;
        x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic logic [4:0] dst_of(input instr_t x);
        return x.regdst ? x.rd : x.rt;
    endfunction

    // Nearest older writer of src wins; $0 is never forwarded.
    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (pipe[1].regwrite && dst_of(pipe[1]) != 5'd0 && dst_of(pipe[1]) == src) return 2'b10;
        if (pipe[2].regwrite && dst_of(pipe[2]) != 5'd0 && dst_of(pipe[2]) == src) return 2'b01;
        return 2'b00;
    endfunction

    // Apply one cycle of inputs, predict outputs, then advance the model over the edge.
    task automatic cycle(input instr_t id, input logic zero, input logic rst);
        logic        taken, lu, stall, jmp;
        logic [1:0]  psel;
        logic [20:0] exp;
        reset = rst;
        {dec_alusrc, dec_regdst, dec_memwrite, dec_memread, dec_beq, dec_bne, dec_jump,
         dec_memtoreg, dec_regwrite, dec_aluop} = id[25:15];
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
        ex_zero = zero;
        if (rst) begin
            pipe[0] = NOP; pipe[1] = NOP; pipe[2] = NOP;
        end
        taken = (pipe[0].beq && zero) || (pipe[0].bne && !zero);
        lu    = pipe[0].memread && pipe[0].rt != 5'd0 &&
                (pipe[0].rt == id.rs || (pipe[0].rt == id.rt && !id.jump));
        stall = lu && !taken;
        jmp   = id.jump && !taken && !lu;
        psel  = taken ? 2'b01 : (jmp ? 2'b10 : 2'b00);
        exp = {pipe[0].alusrc, pipe[0].aluop, pipe[1].memread, pipe[1].memwrite,
               pipe[2].memtoreg, pipe[2].regwrite, dst_of(pipe[2]),
               !stall, !stall, taken || jmp, psel, fwd_ref(pipe[0].rs), fwd_ref(pipe[0].rt)};
        sb_q.push_back(exp);
        last_stall = stall;
        last_flush = taken || jmp;
        @(posedge clk);
        #1;
        if (rst) begin
            pipe[0] = NOP; pipe[1] = NOP; pipe[2] = NOP;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (taken || lu) ? NOP : id;
        end
        cyc++;
    endtask

    // Re-present the instruction while IF/ID is held.
    task automatic issue(input instr_t x, input logic zero);
        cycle(x, zero, 1'b0);
        for (int k = 0; k < 4 && last_stall; k++) cycle(x, zero, 1'b0);
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [20:0] e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {ex_alusrc, ex_aluop, mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite,
                 wb_dst, pc_write, ifid_write, ifid_flush, pc_sel, fwd_a, fwd_b};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d act=%b_%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b_%b",
                         cyc, a[20:12], a[11:7], a[6:4], a[3:2], a[1:0], a,
                         e[20:12], e[11:7], e[6:4], e[3:2], e[1:0], e);
            end
        end
    end

    initial begin
        instr_t cur, t;
        reset = 1'b1;
        {dec_alusrc, dec_regdst, dec_memwrite, dec_memread, dec_beq, dec_bne, dec_jump,
         dec_memtoreg, dec_regwrite, dec_aluop} = 11'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; ex_zero = 1'b0;
        pipe[0] = NOP; pipe[1] = NOP; pipe[2] = NOP;
        @(posedge clk); #1;
        cycle(NOP, 1'b0, 1'b1);
        cycle(NOP, 1'b0, 1'b1);

        // lw then dependent add: one stall, then WB forwarding
        issue(mk_lw(5'd2, 5'd1), 1'b0);
        issue(mk_r(5'd3, 5'd2, 5'd4), 1'b0);
        repeat (3) cycle(NOP, 1'b0, 1'b0);
        // back-to-back R-type dependency: EX/MEM forwarding on both operands
        issue(mk_r(5'd2, 5'd1, 5'd1), 1'b0);
        issue(mk_r(5'd5, 5'd2, 5'd2), 1'b0);
        repeat (3) cycle(NOP, 1'b0, 1'b0);
        // taken beq in EX that also carries a load-use match against ID
        t = mk_br(1'b0, 5'd1, 5'd7);
        t.memread = 1'b1;
        cycle(t, 1'b0, 1'b0);
        cycle(mk_r(5'd3, 5'd7, 5'd4), 1'b1, 1'b0);
        repeat (2) cycle(NOP, 1'b0, 1'b0);
        // taken bne, and jump in ID
        issue(mk_br(1'b1, 5'd1, 5'd2), 1'b0);
        cycle(mk_j(5'd3, 5'd3), 1'b0, 1'b0);
        cycle(NOP, 1'b0, 1'b0);
        cycle(mk_j(5'd0, 5'd0), 1'b0, 1'b0);
        repeat (3) cycle(NOP, 1'b0, 1'b0);
        // jump held by a load-use on rs, then re-evaluated
        issue(mk_lw(5'd6, 5'd1), 1'b0);
        issue(mk_j(5'd6, 5'd0), 1'b0);
        repeat (2) cycle(NOP, 1'b0, 1'b0);
        // $0 destinations: no forwarding, no stall
        issue(mk_r(5'd0, 5'd1, 5'd1), 1'b0);
        issue(mk_r(5'd4, 5'd0, 5'd0), 1'b0);
        issue(mk_lw(5'd0, 5'd1), 1'b0);
        issue(mk_r(5'd3, 5'd0, 5'd0), 1'b0);
        repeat (3) cycle(NOP, 1'b0, 1'b0);
        // reset while sw sits in MEM, then normal load right after
        cycle(mk_sw(5'd2, 5'd1), 1'b0, 1'b0);
        cycle(mk_r(5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        cycle(NOP, 1'b0, 1'b1);
        cycle(mk_lw(5'd5, 5'd1), 1'b0, 1'b0);
        repeat (3) cycle(NOP, 1'b0, 1'b0);

        // Randomized stream over a small register set to provoke hazards.
        cur = NOP;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                if (last_flush) begin
                    cur = NOP;
                end else begin
                    case ($urandom_range(0, 9))
                        0, 1, 2: cur = mk_r(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                        3, 4:    cur = mk_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                        5:       cur = mk_sw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                        6, 7:    cur = mk_br(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                        8:       cur = mk_j(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                        default: begin
                            cur = instr_t'(26'($urandom));
                            cur.rs = 5'($urandom_range(0, 3));
                            cur.rt = 5'($urandom_range(0, 3));
                            cur.rd = 5'($urandom_range(0, 3));
                        end
                    endcase
                end
            end
            if ($urandom_range(0, 99) == 0) cycle(NOP, 1'b0, 1'b1);
            else cycle(cur, 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
